// File: rtl/osc_bank_meter.sv
// osc_bank_meter
//   Selects one of N_OSC free-running on-chip oscillators, brings it into the
//   clk domain, drives a gated (and optionally divided) copy to the
//   observation pad and measures its frequency by counting rising edges over
//   a programmable window of clk cycles.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   osc_in     raw oscillator outputs, asynchronous to clk
//   osc_en     global enable; low gates osc_out and aborts a measurement
//   osc_sel    oscillator select
//   div_ratio  output divide ratio; 0 or 1 passes the synchronised osc through
//   win_len    measurement window in clk cycles; 0 returns an empty result
//   start      single-cycle pulse that begins a measurement
//   osc_out    gated, optionally divided selected oscillator
//   busy       measurement in progress
//   done       one-cycle pulse, edge_cnt/ovf just updated
//   edge_cnt   rising edges counted in the last completed window
//   ovf        count saturated in the last completed window
module osc_bank_meter #(
  parameter int N_OSC = 4,
  parameter int SEL_W = 2,
  parameter int DIV_W = 8,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_OSC-1:0] osc_in,
  input  logic             osc_en,
  input  logic [SEL_W-1:0] osc_sel,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  output logic             osc_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state;
  logic             arm_cnt;

  logic [SEL_W-1:0] sel_lat;
  logic [SEL_W-1:0] sel_eff;
  logic [SEL_W-1:0] sel_prev;
  logic [1:0]       flush_cnt;

  logic             osc_raw;
  logic             sync_p0;
  logic             sync_p1;
  logic             sync_p2;
  logic             rise_p2;

  logic             bypass;
  logic [DIV_W-1:0] div_cnt;
  logic             div_tog;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;
  logic             acc_ovf;
  logic [CNT_W:0]   acc_next;

  // Saturating increment; returns {ovf, count}. An edge arriving while the
  // count is already at full scale sets ovf instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                             input logic             ovf_in,
                                             input logic             inc);
    if (!inc)
      return {ovf_in, cnt};
    if (&cnt)
      return {1'b1, cnt};
    return {ovf_in, cnt + 1'b1};
  endfunction

  // While a measurement runs the latched select is used, so osc_sel changes
  // cannot disturb the count.
  assign sel_eff = (state == IDLE) ? osc_sel : sel_lat;

  always_comb begin
    osc_raw = 1'b0;
    for (int i = 0; i < N_OSC; i++) begin
      if (sel_eff == SEL_W'(i))
        osc_raw = osc_in[i];
    end
  end

  // ---- stage p0..p2: synchroniser and edge detector ----
  // A select change pushes a new oscillator into the chain; the old/new
  // boundary would look like an edge, so detection is masked for the two
  // cycles it takes to flush through sync_p1/sync_p2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      sync_p2   <= 1'b0;
      sel_prev  <= '0;
      flush_cnt <= 2'd0;
    end else begin
      sync_p0  <= osc_raw;
      sync_p1  <= sync_p0;
      sync_p2  <= sync_p1;
      sel_prev <= sel_eff;
      if (sel_eff != sel_prev)
        flush_cnt <= 2'd2;
      else if (flush_cnt != 2'd0)
        flush_cnt <= flush_cnt - 2'd1;
    end
  end

  assign rise_p2 = sync_p1 & ~sync_p2 & (flush_cnt == 2'd0);

  // ---- output divider and pad gating ----
  assign bypass = (div_ratio <= DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_tog <= 1'b0;
      osc_out <= 1'b0;
    end else begin
      if (!osc_en || bypass) begin
        div_cnt <= '0;
        div_tog <= 1'b0;
      end else if (rise_p2) begin
        // >= keeps the divider sane if div_ratio shrinks below div_cnt
        if (div_cnt >= div_ratio - 1'b1) begin
          div_cnt <= '0;
          div_tog <= ~div_tog;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      osc_out <= osc_en & (bypass ? sync_p1 : div_tog);
    end
  end

  // ---- measurement control ----
  assign acc_next = sat_inc(acc, acc_ovf, rise_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      arm_cnt  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (win_len == '0) begin
              done     <= 1'b1;
              edge_cnt <= '0;
              ovf      <= 1'b0;
            end else if (osc_en) begin
              state   <= ARM;
              busy    <= 1'b1;
              arm_cnt <= 1'b0;
            end
          end
        end
        ARM: begin
          if (!osc_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (arm_cnt) begin
            state <= MEASURE;
          end else begin
            arm_cnt <= 1'b1;
          end
        end
        MEASURE: begin
          if (!osc_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (win_cnt == WIN_W'(1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            edge_cnt <= acc_next[CNT_W-1:0];
            ovf      <= acc_next[CNT_W];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- measurement datapath ----
  // Window length and select are captured on the start that leaves IDLE, so
  // later changes to win_len/osc_sel only affect the next measurement.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && osc_en && win_len != '0) begin
      sel_lat <= osc_sel;
      win_cnt <= win_len;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (state == MEASURE) begin
      win_cnt        <= win_cnt - 1'b1;
      {acc_ovf, acc} <= acc_next;
    end
  end

endmodule

// File: tb/tb_osc_bank_meter.sv
module tb_osc_bank_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  osc;
  logic        osc_en;
  logic [1:0]  osc_sel;
  logic [7:0]  div_ratio;
  logic [15:0] win_len;
  logic        start;
  logic        start_s;

  logic        osc_out_m, busy_m, done_m, ovf_m;
  logic [15:0] edge_cnt_m;
  logic        osc_out_s, busy_s, done_s, ovf_s;
  logic [3:0]  edge_cnt_s;

  int per [4];
  int ph  [4];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string nm;
    int    lo;
    int    hi;
    bit    ov;
    int    cyc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t e_m;
  exp_t e_s;

  osc_bank_meter dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc), .osc_en(osc_en),
    .osc_sel(osc_sel), .div_ratio(div_ratio), .win_len(win_len),
    .start(start), .osc_out(osc_out_m), .busy(busy_m), .done(done_m),
    .edge_cnt(edge_cnt_m), .ovf(ovf_m)
  );

  osc_bank_meter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .osc_in(osc), .osc_en(osc_en),
    .osc_sel(osc_sel), .div_ratio(div_ratio), .win_len(win_len),
    .start(start_s), .osc_out(osc_out_s), .busy(busy_s), .done(done_s),
    .edge_cnt(edge_cnt_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave oscillators with a period of per[i] clk cycles (0 = held low)
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (per[i] == 0) begin
        osc[i] = 1'b0;
      end else begin
        ph[i]  = (ph[i] + 1) % per[i];
        osc[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  task automatic check(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Scoreboard monitors: one per instance
  always @(negedge clk) begin
    if (done_m) begin
      if (q_m.size() == 0) begin
        check("main_unexpected_done", 1'b0, 1, 0);
      end else begin
        e_m = q_m.pop_front();
        check_rng({e_m.nm, "_cnt"}, int'(edge_cnt_m), e_m.lo, e_m.hi);
        check({e_m.nm, "_ovf"}, ovf_m == e_m.ov, ovf_m, e_m.ov);
        check({e_m.nm, "_cycle"}, cyc == e_m.cyc, cyc, e_m.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done_s) begin
      if (q_s.size() == 0) begin
        check("sat_unexpected_done", 1'b0, 1, 0);
      end else begin
        e_s = q_s.pop_front();
        check_rng({e_s.nm, "_cnt"}, int'(edge_cnt_s), e_s.lo, e_s.hi);
        check({e_s.nm, "_ovf"}, ovf_s == e_s.ov, ovf_s, e_s.ov);
        check({e_s.nm, "_cycle"}, cyc == e_s.cyc, cyc, e_s.cyc);
      end
    end
  end

  // Issue a start and push the expected result; done is due win_len+3
  // cycles after the start cycle, or 1 cycle for an empty window.
  task automatic run(input string nm, input int w, input int lo, input int hi,
                     input bit ov, input bit on_sat);
    exp_t e;
    @(negedge clk);
    win_len = 16'(w);
    e.nm = nm; e.lo = lo; e.hi = hi; e.ov = ov;
    e.cyc = cyc + ((w == 0) ? 1 : w + 3);
    if (on_sat) begin
      start_s = 1'b1;
      q_s.push_back(e);
    end else begin
      start = 1'b1;
      q_m.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    start_s = 1'b0;
  endtask

  // Start with no result expected (ignored, aborted or reset runs)
  task automatic poke_start(input int w);
    @(negedge clk);
    win_len = 16'(w);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_m.size() == 0 && q_s.size() == 0) break;
      @(negedge clk);
    end
    check("drain", q_m.size() == 0 && q_s.size() == 0, q_m.size() + q_s.size(), 0);
    q_m.delete();
    q_s.delete();
  endtask

  task automatic wait_edge(input bit rising, output int t);
    logic prev;
    t = -1;
    prev = osc_out_m;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (osc_out_m != prev && osc_out_m == rising) begin
        t = cyc;
        break;
      end
      prev = osc_out_m;
    end
  endtask

  task automatic meas_out(output int period, output int high);
    int t0, t1, t2;
    wait_edge(1'b1, t0);
    wait_edge(1'b0, t1);
    wait_edge(1'b1, t2);
    if (t0 < 0 || t1 < 0 || t2 < 0) begin
      period = -1;
      high   = -1;
    end else begin
      period = t2 - t0;
      high   = t1 - t0;
    end
  endtask

  initial begin
    int p, h, t, hi_cnt;
    rst_n = 1'b0; osc_en = 1'b0; osc_sel = 2'd0; div_ratio = 8'd0;
    win_len = 16'd0; start = 1'b0; start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      per[i] = 0;
      ph[i]  = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy_m == 1'b0, busy_m, 0);
    check("rst_done", done_m == 1'b0, done_m, 0);
    check("rst_edge_cnt", edge_cnt_m == 16'd0, edge_cnt_m, 0);
    check("rst_ovf", ovf_m == 1'b0, ovf_m, 0);
    check("rst_osc_out", osc_out_m == 1'b0, osc_out_m, 0);

    @(negedge clk);
    rst_n = 1'b1; osc_en = 1'b1;
    per[0] = 4; per[2] = 8; per[3] = 4;
    repeat (20) @(negedge clk);

    // Frequency count with start re-pulsed (and win_len changed) while busy
    osc_sel = 2'd2;
    run("freq", 800, 99, 101, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("freq_busy", busy_m == 1'b1, busy_m, 1);
    repeat (100) @(negedge clk);
    poke_start(50);
    wait_drain(1000);
    check("freq_busy_after", busy_m == 1'b0, busy_m, 0);

    // Abort at window cycle 10: no done, previous result retained
    poke_start(100);
    repeat (12) @(negedge clk);
    check("abort_busy_before", busy_m == 1'b1, busy_m, 1);
    osc_en = 1'b0;
    @(negedge clk);
    check("abort_busy_after", busy_m == 1'b0, busy_m, 0);
    osc_en = 1'b1;
    repeat (150) @(negedge clk);
    check_rng("abort_retained_cnt", int'(edge_cnt_m), 99, 101);

    // start coinciding with osc_en falling: nothing begins
    @(negedge clk);
    win_len = 16'd50; start = 1'b1; osc_en = 1'b0;
    @(negedge clk);
    start = 1'b0; osc_en = 1'b1;
    check("start_en_low_busy", busy_m == 1'b0, busy_m, 0);
    repeat (80) @(negedge clk);

    // Select changed mid-window: count stays on the latched oscillator
    osc_sel = 2'd2;
    run("selsw", 400, 49, 51, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    osc_sel = 2'd0;
    wait_drain(600);

    // Zero window
    run("zero", 0, 0, 0, 1'b0, 1'b0);
    wait_drain(10);

    // Saturation on the 4-bit-counter instance, then a run that fits
    osc_sel = 2'd3;
    repeat (20) @(negedge clk);
    run("sat", 200, 15, 15, 1'b1, 1'b1);
    wait_drain(300);
    run("sat2", 20, 4, 6, 1'b0, 1'b1);
    wait_drain(100);

    // Divider: ratio 3 on a 6-cycle oscillator
    per[3] = 6;
    div_ratio = 8'd3;
    repeat (60) @(negedge clk);
    meas_out(p, h);
    check("div3_period", p == 36, p, 36);
    check("div3_high", h == 18, h, 18);

    // Gating while the divided output is high
    wait_edge(1'b1, t);
    check("gate_found_high", t >= 0, t, 0);
    osc_en = 1'b0;
    @(negedge clk);
    check("gate_osc_out", osc_out_m == 1'b0, osc_out_m, 0);
    hi_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (osc_out_m) hi_cnt++;
    end
    check("gate_stays_low", hi_cnt == 0, hi_cnt, 0);
    osc_en = 1'b1;

    // Pass-through
    div_ratio = 8'd0;
    repeat (20) @(negedge clk);
    meas_out(p, h);
    check("bypass_period", p == 6, p, 6);
    check("bypass_high", h == 3, h, 3);

    // Reset during MEASURE
    osc_sel = 2'd2;
    poke_start(500);
    repeat (30) @(negedge clk);
    check("mrst_busy_before", busy_m == 1'b1, busy_m, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy_m == 1'b0, busy_m, 0);
    check("mrst_done", done_m == 1'b0, done_m, 0);
    check("mrst_edge_cnt", edge_cnt_m == 16'd0, edge_cnt_m, 0);
    check("mrst_osc_out", osc_out_m == 1'b0, osc_out_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_idle", busy_m == 1'b0, busy_m, 0);
    run("post_rst_zero", 0, 0, 0, 1'b0, 1'b0);
    wait_drain(10);
    repeat (600) @(negedge clk);
    check("final_idle", busy_m == 1'b0, busy_m, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
